// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: FSM state encoding
// and the default grant-hold limit.
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: returns the first requesting index
// in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       any
);

  logic [7:0] dbl;
  logic [3:0] rot;
  logic [1:0] off;

  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[3:0];
    off = 2'd0;
    // Scan high to low so the lowest set bit (closest to ptr) wins.
    for (int i = 3; i >= 0; i--) begin
      if (rot[i]) off = 2'(i);
    end
    idx = ptr + off;
    any = |req;
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// 4-requester round-robin arbiter with grant-hold timeout. Registered outputs;
// a grant holds until done or until TIMEOUT cycles elapse.
module rr_arbiter_4
  import rr_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] cnt;
  logic [1:0] pick_idx;
  logic       pick_any;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      gnt_idx <= 2'd0;
      gnt_vld <= 1'b0;
      timeout <= 1'b0;
      cnt     <= 8'd0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt_idx <= pick_idx;
            gnt_vld <= 1'b1;
            cnt     <= 8'd0;
            state   <= GRANT;
          end
        end
        GRANT: begin
          // done takes priority over a coincident timeout.
          if (done) begin
            gnt_vld <= 1'b0;
            ptr     <= gnt_idx + 2'd1;
            state   <= IDLE;
          end else if (cnt == CNT_LAST) begin
            gnt_vld <= 1'b0;
            ptr     <= gnt_idx + 2'd1;
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: table-driven grant/release vectors
// plus hand-written timeout, hold-stability and async-reset sequences.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int n_tests;
  int n_fail;

  rr_arbiter_4 #(.TIMEOUT(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [1:0] idx;
    logic       vld;
    logic       to;
  } vec_t;

  vec_t vecs[20];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input int idx, input int vld, input int to);
    check({name, " idx"}, int'(gnt_idx), idx);
    check({name, " vld"}, int'(gnt_vld), vld);
    check({name, " timeout"}, int'(timeout), to);
  endtask

  initial begin
    int cnt;
    int guard;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;

    // req=0101 alternation, then 1111 wrap from ptr=3, then done ignored in IDLE
    vecs[0]  = '{4'b0101, 1'b0, 2'd0, 1'b1, 1'b0};
    vecs[1]  = '{4'b0101, 1'b1, 2'd0, 1'b0, 1'b0};
    vecs[2]  = '{4'b0101, 1'b0, 2'd2, 1'b1, 1'b0};
    vecs[3]  = '{4'b0101, 1'b1, 2'd2, 1'b0, 1'b0};
    vecs[4]  = '{4'b0101, 1'b0, 2'd0, 1'b1, 1'b0};
    vecs[5]  = '{4'b0101, 1'b1, 2'd0, 1'b0, 1'b0};
    vecs[6]  = '{4'b0101, 1'b0, 2'd2, 1'b1, 1'b0};
    vecs[7]  = '{4'b0101, 1'b1, 2'd2, 1'b0, 1'b0};
    vecs[8]  = '{4'b1111, 1'b0, 2'd3, 1'b1, 1'b0};
    vecs[9]  = '{4'b1111, 1'b1, 2'd3, 1'b0, 1'b0};
    vecs[10] = '{4'b1111, 1'b0, 2'd0, 1'b1, 1'b0};
    vecs[11] = '{4'b1111, 1'b1, 2'd0, 1'b0, 1'b0};
    vecs[12] = '{4'b1111, 1'b0, 2'd1, 1'b1, 1'b0};
    vecs[13] = '{4'b1111, 1'b1, 2'd1, 1'b0, 1'b0};
    vecs[14] = '{4'b1111, 1'b0, 2'd2, 1'b1, 1'b0};
    vecs[15] = '{4'b1111, 1'b1, 2'd2, 1'b0, 1'b0};
    vecs[16] = '{4'b0000, 1'b1, 2'd2, 1'b0, 1'b0};
    vecs[17] = '{4'b0010, 1'b1, 2'd1, 1'b1, 1'b0};
    vecs[18] = '{4'b0000, 1'b0, 2'd1, 1'b1, 1'b0};
    vecs[19] = '{4'b0000, 1'b1, 2'd1, 1'b0, 1'b0};

    repeat (2) step();
    check_out("reset", 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      req  = vecs[i].req;
      done = vecs[i].done;
      step();
      check_out($sformatf("vec%0d", i), int'(vecs[i].idx), int'(vecs[i].vld), int'(vecs[i].to));
    end
    done = 1'b0;

    // Timeout on idx 1 (ptr=2 here, only requester 1 asks)
    req = 4'b0010;
    step();
    check_out("to_grant", 1, 1, 0);
    cnt = 1;
    guard = 0;
    while (gnt_vld && guard < 40) begin
      step();
      guard++;
      if (gnt_vld) begin
        cnt++;
        check("to_hold timeout", int'(timeout), 0);
      end
    end
    check("to_hold cycles", cnt, 16);
    check("to_pulse", int'(timeout), 1);
    req = 4'b1111;
    step();
    check_out("to_next", 2, 1, 0);
    done = 1'b1;
    step();
    check_out("to_next_rel", 2, 0, 0);
    done = 1'b0;

    // done on the exact timeout edge: normal release
    step();
    check_out("race_grant", 3, 1, 0);
    repeat (15) step();
    check_out("race_hold", 3, 1, 0);
    done = 1'b1;
    step();
    check_out("race_rel", 3, 0, 0);
    done = 1'b0;
    step();
    check_out("race_after", 0, 1, 0);

    // req changes during GRANT on idx 0 do not disturb the grant
    req = 4'b0000;
    step();
    check_out("hold_req0", 0, 1, 0);
    req = 4'b1110;
    step();
    check_out("hold_req1110", 0, 1, 0);
    done = 1'b1;
    step();
    check_out("hold_rel", 0, 0, 0);
    done = 1'b0;
    step();
    check_out("hold_next", 1, 1, 0);
    done = 1'b1;
    step();
    done = 1'b0;

    // Asynchronous reset mid-GRANT
    req = 4'b1111;
    step();
    check_out("rst_grant", 2, 1, 0);
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_out("rst_async", 0, 0, 0);
    step();
    check_out("rst_held", 0, 0, 0);
    rst_n = 1'b1;
    req = 4'b1000;
    #2;
    check_out("rst_released", 0, 0, 0);
    step();
    check_out("rst_first", 3, 1, 0);
    done = 1'b1;
    step();
    check_out("rst_first_rel", 3, 0, 0);
    done = 1'b0;
    req = 4'b0011;
    step();
    check_out("rst_ptr", 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4.md
RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, maximum grant-hold cycles before forced release (range 2..255).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req  input  4  request per requester; bit i = requester i.
REQ-005 SHALL have port: done  input  1  current grant holder releases; sampled only in GRANT.
REQ-006 SHALL have port: gnt_idx  output  2  binary index of granted requester; feeds the 2-to-4 decoder stage downstream.
REQ-007 SHALL have port: gnt_vld  output  1  gnt_idx valid; downstream one-hot enable qualified by it.
REQ-008 SHALL have port: timeout  output  1  one-cycle pulse when a grant is forcibly released.

Function
REQ-009 SHALL implement a two-state FSM: IDLE, GRANT.
REQ-010 SHALL keep a 2-bit priority pointer ptr; search order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-011 In IDLE with req != 0 at edge N, SHALL register the first requesting index in search order into gnt_idx, set gnt_vld=1 and enter GRANT, visible after edge N (one-cycle latency).
REQ-012 In IDLE with req == 0, SHALL stay in IDLE, gnt_vld=0, gnt_idx holds last value.
REQ-013 In GRANT, gnt_idx and gnt_vld SHALL be stable regardless of req changes; dropping req[gnt_idx] does not release.
REQ-014 In GRANT with done=1 at an edge, SHALL clear gnt_vld, set ptr=gnt_idx+1 (mod 4, 3 wraps to 0), return to IDLE.
REQ-015 SHALL count grant-hold cycles with an 8-bit counter cleared on GRANT entry, incremented each GRANT cycle without done.
REQ-016 When the counter reaches TIMEOUT-1 with done=0, SHALL release exactly as REQ-014 and pulse timeout=1 for that following cycle.
REQ-017 If done=1 on the same edge as the timeout condition, done SHALL win; timeout stays 0.
REQ-018 After any release, at least one IDLE cycle (gnt_vld=0) SHALL occur before the next grant.
REQ-019 done in IDLE SHALL be ignored.
REQ-020 With a single persistent requester, SHALL re-grant it after each release (one-cycle bubble).

Reset
REQ-021 rst_n low SHALL immediately force: state=IDLE, ptr=0, gnt_idx=0, gnt_vld=0, timeout=0, counter=0.
REQ-022 Reset asserted mid-GRANT SHALL abort the grant with no timeout pulse.
REQ-023 First grant after reset release SHALL occur no earlier than the first rising edge with rst_n high.

Structure
REQ-024 Shared package rr_arb_pkg SHALL hold the state encoding (IDLE=0, GRANT=1) and default TIMEOUT constant.
REQ-025 Rotating-priority pick SHALL be a combinational sub-module rr_pick4 (inputs req, ptr; outputs idx, any).
REQ-026 All outputs SHALL be driven from registers (no combinational path req->gnt_idx).

Verification
REQ-027 Reset, then req=4'b0101 held, done pulsed 1 cycle after each grant -> gnt_idx sequence 0,2,0,2 each with one gnt_vld=0 bubble between.
REQ-028 req=4'b1111, ptr=3 after granting 2 -> next grant idx=3, then 0, 1, 2 (wrap check).
REQ-029 Grant idx=1, never assert done, TIMEOUT=16 -> gnt_vld high exactly 16 cycles, timeout pulses 1 cycle at release, next grant from idx 2 onward.
REQ-030 done asserted on the exact timeout cycle -> normal release, timeout stays 0.
REQ-031 rst_n pulled low mid-GRANT asynchronously -> gnt_vld=0 and gnt_idx=0 before next clk edge; after release req=4'b1000 -> idx=3 granted one cycle later.
REQ-032 During GRANT on idx 0, toggle req to 4'b0000 and 4'b1110 -> gnt_idx/gnt_vld unchanged until done.
